vga_sync_gen: RTL

Generates the VGA raster timing that drives the monitor and that every downstream consumer of `VGA_VS`/`VGA_HS` (frame parity tracking, sprite/background draw logic) keys off. It divides the system clock into a pixel-enable strobe and runs horizontal and vertical counters over a 640x480@60 Hz frame. From those counters it produces active-low syncs, blanking, the current pixel coordinate and single-cycle line/frame markers. It sits between the system clock domain and the DE-series VGA DAC pins.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/pix_strobe_div.sv | 30 +++
 rtl/vga_sync_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and the coordinate type used by the sync generator.
package vga_pkg;

  typedef logic [9:0] vga_coord_t;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(vga_coord_t v, vga_coord_t lo, vga_coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pix_strobe_div.sv
// Clock divider producing a one-Clk pixel-enable strobe every CLK_DIV system clocks.
module pix_strobe_div #(
  parameter int CLK_DIV = 2
) (
  input  logic Clk,
  input  logic Reset,
  output logic pix_en
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic             strobe_reg;

  // Strobe is registered off the terminal count: it is low out of reset and
  // first rises CLK_DIV cycles after release (1 cycle when CLK_DIV = 1).
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_reg    <= '0;
      strobe_reg <= 1'b0;
    end else begin
      div_reg    <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
      strobe_reg <= (div_reg == DIV_LAST);
    end
  end

  assign pix_en = strobe_reg;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel strobe, H/V counters, registered syncs/blank and line/frame markers.
// Optional frame counter enabled by defining VGA_FRAME_COUNT_EN.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        pix_en,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam vga_coord_t H_LAST   = vga_coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam vga_coord_t V_LAST   = vga_coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam vga_coord_t H_VIS    = vga_coord_t'(H_VISIBLE);
  localparam vga_coord_t V_VIS    = vga_coord_t'(V_VISIBLE);
  localparam vga_coord_t HS_START = vga_coord_t'(H_VISIBLE + H_FRONT);
  localparam vga_coord_t HS_END   = vga_coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam vga_coord_t VS_START = vga_coord_t'(V_VISIBLE + V_FRONT);
  localparam vga_coord_t VS_END   = vga_coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       pix_en_w;
  vga_coord_t x_reg, y_reg, x_next, y_next;
  logic       line_wrap, frame_wrap;
  logic       hs_reg, vs_reg, blank_n_reg, line_start_reg, frame_start_reg;

  pix_strobe_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_strobe_div (
    .Clk    (Clk),
    .Reset  (Reset),
    .pix_en (pix_en_w)
  );

  always_comb begin
    x_next     = x_reg;
    y_next     = y_reg;
    line_wrap  = pix_en_w && (x_reg == H_LAST);
    frame_wrap = line_wrap && (y_reg == V_LAST);
    if (pix_en_w) begin
      if (x_reg == H_LAST) begin
        x_next = '0;
        y_next = (y_reg == V_LAST) ? '0 : vga_coord_t'(y_reg + 1'b1);
      end else begin
        x_next = vga_coord_t'(x_reg + 1'b1);
      end
    end
  end

  // Syncs and blank are decoded from the next counter values so they change
  // on the same edge as DrawX/DrawY.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      x_reg           <= '0;
      y_reg           <= '0;
      hs_reg          <= 1'b1;
      vs_reg          <= 1'b1;
      blank_n_reg     <= 1'b1;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      x_reg           <= x_next;
      y_reg           <= y_next;
      hs_reg          <= !in_window(x_next, HS_START, HS_END);
      vs_reg          <= !in_window(y_next, VS_START, VS_END);
      blank_n_reg     <= (x_next < H_VIS) && (y_next < V_VIS);
      line_start_reg  <= line_wrap;
      frame_start_reg <= frame_wrap;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_count_reg <= '0;
    end else if (frame_wrap) begin
      frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign frame_count = frame_count_reg;
`else
  assign frame_count = 16'd0;
`endif

  assign pix_en      = pix_en_w;
  assign VGA_HS      = hs_reg;
  assign VGA_VS      = vs_reg;
  assign VGA_BLANK_N = blank_n_reg;
  assign VGA_SYNC_N  = 1'b0;
  assign DrawX       = x_reg;
  assign DrawY       = y_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule
